// File: rtl/lag_correlator.sv
// lag_correlator: finds, for each of three signal capture vectors, the bit lag
// (0..NLAG-1) that best aligns it with a reference vector. One lag is scored
// per clock for all three channels at once, using an XNOR popcount over an
// NWIN-bit window. Results are published with a single-cycle done pulse.
module lag_correlator #(
  parameter  int NDATA      = 128,
  parameter  int NLAG       = 32,
  localparam int NWIN       = NDATA - NLAG,
  localparam int NLAG_LOG   = $clog2(NLAG),
  localparam int NSCORE_LOG = $clog2(NWIN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NDATA-1:0]      dinRef,
  input  logic [NDATA-1:0]      dinSigA,
  input  logic [NDATA-1:0]      dinSigB,
  input  logic [NDATA-1:0]      dinSigC,
  output logic [NLAG_LOG-1:0]   lagA,
  output logic [NLAG_LOG-1:0]   lagB,
  output logic [NLAG_LOG-1:0]   lagC,
  output logic [NSCORE_LOG-1:0] scoreA,
  output logic [NSCORE_LOG-1:0] scoreB,
  output logic [NSCORE_LOG-1:0] scoreC,
  output logic                  busy,
  output logic                  done
);

  localparam int NCH = 3;
  localparam logic [NLAG_LOG-1:0] LAST_LAG = NLAG_LOG'(NLAG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [NWIN-1:0]       ref_q;
  logic [NDATA-1:0]      sig_q        [NCH];
  logic [NLAG_LOG-1:0]   k_q;
  logic [NSCORE_LOG-1:0] best_score_q [NCH];
  logic [NLAG_LOG-1:0]   best_lag_q   [NCH];
  logic [NSCORE_LOG-1:0] score_q      [NCH];
  logic [NLAG_LOG-1:0]   lag_q        [NCH];
  logic                  busy_q;
  logic                  done_q;

  logic [NDATA-1:0]      din_sig      [NCH];
  logic [NSCORE_LOG-1:0] match_cnt    [NCH];

  // Counts set bits; the result never exceeds NWIN so it cannot overflow.
  function automatic logic [NSCORE_LOG-1:0] popcount(input logic [NWIN-1:0] v);
    logic [NSCORE_LOG-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NWIN; i++) begin
      cnt = cnt + NSCORE_LOG'(v[i]);
    end
    return cnt;
  endfunction

  assign din_sig[0] = dinSigA;
  assign din_sig[1] = dinSigB;
  assign din_sig[2] = dinSigC;

  // Per-channel match metric at the current lag: window sig[i+k] vs ref[i].
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic [NWIN-1:0] win;
      assign win            = NWIN'(sig_q[gi] >> k_q);
      assign match_cnt[gi]  = popcount(~(ref_q ^ win));
    end
  endgenerate

  // Run control: snapshot on start, scan one lag per cycle, then publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ref_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        sig_q[c]        <= '0;
        best_score_q[c] <= '0;
        best_lag_q[c]   <= '0;
        score_q[c]      <= '0;
        lag_q[c]        <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ref_q <= NWIN'(dinRef);
            for (int c = 0; c < NCH; c++) begin
              sig_q[c]        <= din_sig[c];
              best_score_q[c] <= '0;
              best_lag_q[c]   <= '0;
            end
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Strict compare keeps the smaller lag on ties; lag 0 always loads
          // so a zero-match first lag is still recorded.
          for (int c = 0; c < NCH; c++) begin
            if ((k_q == '0) || (match_cnt[c] > best_score_q[c])) begin
              best_score_q[c] <= match_cnt[c];
              best_lag_q[c]   <= k_q;
            end
          end
          k_q <= k_q + NLAG_LOG'(1);
          if (k_q == LAST_LAG) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          for (int c = 0; c < NCH; c++) begin
            score_q[c] <= best_score_q[c];
            lag_q[c]   <= best_lag_q[c];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign lagA   = lag_q[0];
  assign lagB   = lag_q[1];
  assign lagC   = lag_q[2];
  assign scoreA = score_q[0];
  assign scoreB = score_q[1];
  assign scoreC = score_q[2];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
